// File: rtl/board_move_writer.sv
// board_move_writer: accepts player moves, checks legality, writes the board,
// hands each written cell to an external win checker and sweeps the board clear
// on new_game. Optional single-level undo is built when BOARD_MOVE_UNDO_EN is defined.
module board_move_writer #(
  parameter int unsigned BOARD_SIZE = 10
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       move_valid,
  input  logic [3:0] move_x,
  input  logic [3:0] move_y,
  output logic       move_ready,
  output logic       move_accept,
  output logic       move_reject,
  output logic [1:0] reject_code,
  output logic [3:0] recent_x,
  output logic [3:0] recent_y,
  output logic [1:0] piece_type,
  output logic       check_req,
  input  logic       win_in,
  input  logic [3:0] rd_x,
  input  logic [3:0] rd_y,
  output logic [1:0] rd_piece,
  output logic [1:0] turn,
  output logic [6:0] move_count,
  output logic       game_over,
  output logic [1:0] winner,
  input  logic       new_game,
  input  logic       undo_req
);

  localparam logic [6:0] FULL_COUNT = 7'(BOARD_SIZE * BOARD_SIZE);
  localparam logic [3:0] LAST_ROW   = 4'(BOARD_SIZE - 1);

  typedef enum logic [1:0] {ST_IDLE, ST_CHECK, ST_DONE, ST_CLEAR} state_t;

  state_t     state, state_d;
  logic [1:0] board [BOARD_SIZE][BOARD_SIZE];
  logic [3:0] clr_row;
  logic       in_range;
  logic [1:0] target_piece;
  logic       undo_ok;
  logic       do_write, do_reject, do_undo;
  logic       start_clear, clear_row, sweep_done;
  logic       check_win, check_draw, check_next;
  logic [1:0] reject_code_d;

  assign in_range    = (32'(move_x) < BOARD_SIZE) && (32'(move_y) < BOARD_SIZE);
  assign move_accept = check_req;

`ifdef BOARD_MOVE_UNDO_EN
  logic undo_avail;

  assign undo_ok = undo_req && (move_count != 7'd0) && undo_avail;

  // One level of undo: armed by a write, spent by an undo or a fresh game
  always_ff @(posedge clk) begin
    if (rst) begin
      undo_avail <= 1'b0;
    end else if (start_clear || do_undo) begin
      undo_avail <= 1'b0;
    end else if (do_write) begin
      undo_avail <= 1'b1;
    end
  end
`else
  logic unused_undo;

  assign unused_undo = undo_req;
  assign undo_ok     = 1'b0;
`endif

  // Cell lookups for the move target and the shared read port (00 off-board)
  always_comb begin
    target_piece = 2'b00;
    rd_piece     = 2'b00;
    for (int y = 0; y < BOARD_SIZE; y++) begin
      for (int x = 0; x < BOARD_SIZE; x++) begin
        if (4'(y) == move_y && 4'(x) == move_x) target_piece = board[y][x];
        if (4'(y) == rd_y && 4'(x) == rd_x) rd_piece = board[y][x];
      end
    end
  end

  // State register
  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_d;
  end

  // Next-state and datapath strobes; new_game pre-empts everything
  always_comb begin
    state_d       = state;
    do_write      = 1'b0;
    do_reject     = 1'b0;
    do_undo       = 1'b0;
    start_clear   = 1'b0;
    clear_row     = 1'b0;
    sweep_done    = 1'b0;
    check_win     = 1'b0;
    check_draw    = 1'b0;
    check_next    = 1'b0;
    reject_code_d = 2'b00;
    move_ready    = (state == ST_IDLE) && !new_game;
    if (new_game) begin
      state_d     = ST_CLEAR;
      start_clear = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          if (undo_ok) begin
            do_undo = 1'b1;
          end else if (move_valid) begin
            if (!in_range) begin
              do_reject     = 1'b1;
              reject_code_d = 2'b01;
            end else if (target_piece != 2'b00) begin
              do_reject     = 1'b1;
              reject_code_d = 2'b10;
            end else begin
              do_write = 1'b1;
              state_d  = ST_CHECK;
            end
          end
        end
        ST_CHECK: begin
          if (win_in) begin
            check_win = 1'b1;
            state_d   = ST_DONE;
          end else if (move_count == FULL_COUNT) begin
            check_draw = 1'b1;
            state_d    = ST_DONE;
          end else begin
            check_next = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        ST_DONE: state_d = ST_DONE;
        ST_CLEAR: begin
          clear_row = 1'b1;
          if (clr_row == LAST_ROW) begin
            sweep_done = 1'b1;
            state_d    = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // Board storage: reset wipes every cell, sweep clears a row, move/undo touch one cell
  always_ff @(posedge clk) begin
    for (int y = 0; y < BOARD_SIZE; y++) begin
      for (int x = 0; x < BOARD_SIZE; x++) begin
        if (rst || (clear_row && 4'(y) == clr_row)) begin
          board[y][x] <= 2'b00;
        end else if (do_write && 4'(y) == move_y && 4'(x) == move_x) begin
          board[y][x] <= turn;
        end else if (do_undo && 4'(y) == recent_y && 4'(x) == recent_x) begin
          board[y][x] <= 2'b00;
        end
      end
    end
  end

  // Game bookkeeping and registered status pulses
  always_ff @(posedge clk) begin
    if (rst) begin
      clr_row     <= 4'd0;
      recent_x    <= 4'd0;
      recent_y    <= 4'd0;
      piece_type  <= 2'b00;
      turn        <= 2'b01;
      move_count  <= 7'd0;
      game_over   <= 1'b0;
      winner      <= 2'b00;
      check_req   <= 1'b0;
      move_reject <= 1'b0;
      reject_code <= 2'b00;
    end else begin
      move_reject <= do_reject;
      reject_code <= reject_code_d;
      check_req   <= (state_d == ST_CHECK);
      if (start_clear)    clr_row <= 4'd0;
      else if (clear_row) clr_row <= clr_row + 4'd1;
      if (do_write) begin
        recent_x   <= move_x;
        recent_y   <= move_y;
        piece_type <= turn;
        move_count <= move_count + 7'd1;
      end else if (do_undo) begin
        move_count <= move_count - 7'd1;
        turn       <= {turn[0], turn[1]};
      end else if (check_win) begin
        game_over <= 1'b1;
        winner    <= piece_type;
      end else if (check_draw) begin
        game_over <= 1'b1;
        winner    <= 2'b11;
      end else if (check_next) begin
        turn <= {turn[0], turn[1]};
      end else if (sweep_done) begin
        turn       <= 2'b01;
        move_count <= 7'd0;
        game_over  <= 1'b0;
        winner     <= 2'b00;
      end
    end
  end

endmodule

// File: tb/tb_board_move_writer.sv
// Self-checking bench for board_move_writer (10x10 instance plus a 2x2 instance for the draw case).
`timescale 1ns/1ps
module tb_board_move_writer;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst;
  logic       move_valid, move_ready, move_accept, move_reject, check_req, win_in;
  logic [3:0] move_x, move_y, recent_x, recent_y, rd_x, rd_y;
  logic [1:0] reject_code, piece_type, rd_piece, turn, winner;
  logic [6:0] move_count;
  logic       game_over, new_game, undo_req;

  logic       s_valid, s_ready, s_accept, s_reject, s_check_req, s_over;
  logic [3:0] s_x, s_y, s_recent_x, s_recent_y, s_rd_x, s_rd_y;
  logic [1:0] s_code, s_piece, s_rd_piece, s_turn, s_winner;
  logic [6:0] s_count;
  logic       s_win, s_new_game, s_undo;

  board_move_writer #(.BOARD_SIZE(10)) u_dut (
    .clk(clk), .rst(rst), .move_valid(move_valid), .move_x(move_x), .move_y(move_y),
    .move_ready(move_ready), .move_accept(move_accept), .move_reject(move_reject),
    .reject_code(reject_code), .recent_x(recent_x), .recent_y(recent_y),
    .piece_type(piece_type), .check_req(check_req), .win_in(win_in),
    .rd_x(rd_x), .rd_y(rd_y), .rd_piece(rd_piece), .turn(turn), .move_count(move_count),
    .game_over(game_over), .winner(winner), .new_game(new_game), .undo_req(undo_req)
  );

  board_move_writer #(.BOARD_SIZE(2)) u_d2 (
    .clk(clk), .rst(rst), .move_valid(s_valid), .move_x(s_x), .move_y(s_y),
    .move_ready(s_ready), .move_accept(s_accept), .move_reject(s_reject),
    .reject_code(s_code), .recent_x(s_recent_x), .recent_y(s_recent_y),
    .piece_type(s_piece), .check_req(s_check_req), .win_in(s_win),
    .rd_x(s_rd_x), .rd_y(s_rd_y), .rd_piece(s_rd_piece), .turn(s_turn), .move_count(s_count),
    .game_over(s_over), .winner(s_winner), .new_game(s_new_game), .undo_req(s_undo)
  );

  typedef struct {
    logic       acc;
    logic [1:0] code;
    logic [3:0] x;
    logic [3:0] y;
    logic [1:0] piece;
  } exp_t;

  typedef struct {
    logic [3:0] x;
    logic [3:0] y;
    logic       win;
    logic       acc;
    logic [1:0] code;
    logic [1:0] piece;
    logic [1:0] turn_after;
    int         cnt_after;
    logic [1:0] rd_after;
    logic       over;
    logic [1:0] winner;
  } vec_t;

  exp_t sb[$];
  int   total = 0;
  int   bad   = 0;
  vec_t vec [10];
  logic [1:0] next_piece;

  task automatic check(input string nm, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, exp);
    end
  endtask

  function automatic exp_t mke(input int acc, input int code, input int x, input int y,
                               input int piece);
    exp_t e;
    e.acc = 1'(acc); e.code = 2'(code); e.x = 4'(x); e.y = 4'(y); e.piece = 2'(piece);
    return e;
  endfunction

  function automatic vec_t mk(input int x, input int y, input int win, input int acc,
                              input int code, input int piece, input int trn, input int cnt,
                              input int rd, input int over, input int wnr);
    vec_t v;
    v.x = 4'(x); v.y = 4'(y); v.win = 1'(win); v.acc = 1'(acc); v.code = 2'(code);
    v.piece = 2'(piece); v.turn_after = 2'(trn); v.cnt_after = cnt; v.rd_after = 2'(rd);
    v.over = 1'(over); v.winner = 2'(wnr);
    return v;
  endfunction

  // Scoreboard: every accept/reject pulse must match the oldest pending expectation
  always @(negedge clk) begin : mon
    exp_t e;
    if (!rst && (move_accept || move_reject)) begin
      if (sb.size() == 0) begin
        check("unexpected_pulse", int'({move_accept, move_reject}), 0);
      end else begin
        e = sb.pop_front();
        check("pulse_accept", int'(move_accept), int'(e.acc));
        check("pulse_reject", int'(move_reject), int'(!e.acc));
        if (e.acc) begin
          check("check_req", int'(check_req), 1);
          check("recent_x", int'(recent_x), int'(e.x));
          check("recent_y", int'(recent_y), int'(e.y));
          check("piece_type", int'(piece_type), int'(e.piece));
        end else begin
          check("reject_code", int'(reject_code), int'(e.code));
        end
      end
    end
  end

  task automatic do_move(input int x, input int y, input int win, input int und, input exp_t e);
    int n;
    n = 0;
    while (!move_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!move_ready) begin
      check("ready_timeout", int'(move_ready), 1);
    end else begin
      move_valid = 1'b1; move_x = 4'(x); move_y = 4'(y); undo_req = 1'(und);
      sb.push_back(e);
      @(posedge clk); #1;
      move_valid = 1'b0; undo_req = 1'b0; win_in = 1'(win);
      @(posedge clk); #1;
      win_in = 1'b0;
      check("sb_drained", sb.size(), 0);
      sb.delete();
    end
  endtask

  // Counts CLEAR cycles until move_ready returns; also checks row 0 clears on the first sweep edge
  task automatic count_clear(input int first_val, output int cyc);
    cyc = 40;
    rd_x = 4'd0; rd_y = 4'd0;
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      if (move_ready) begin
        cyc = k;
        break;
      end
      if (k == 0) check("sweep_row0_before", int'(rd_piece), first_val);
      if (k == 1) check("sweep_row0_after", int'(rd_piece), 0);
    end
    @(posedge clk); #1;
  endtask

  task automatic check_board_empty(input string nm);
    int nz;
    nz = 0;
    for (int y = 0; y < 10; y++) begin
      for (int x = 0; x < 10; x++) begin
        rd_x = 4'(x); rd_y = 4'(y); #0.01;
        if (rd_piece != 2'b00) nz++;
      end
    end
    check(nm, nz, 0);
  endtask

  task automatic check_fresh(input string nm);
    check({nm, "_turn"}, int'(turn), 1);
    check({nm, "_count"}, int'(move_count), 0);
    check({nm, "_over"}, int'(game_over), 0);
    check({nm, "_winner"}, int'(winner), 0);
    check({nm, "_ready"}, int'(move_ready), 1);
  endtask

  initial begin
    int cyc;
    int pulses;
    rst = 1'b1; move_valid = 1'b0; move_x = 4'd0; move_y = 4'd0; win_in = 1'b0;
    rd_x = 4'd0; rd_y = 4'd0; new_game = 1'b0; undo_req = 1'b0;
    s_valid = 1'b0; s_x = 4'd0; s_y = 4'd0; s_win = 1'b0; s_rd_x = 4'd0; s_rd_y = 4'd0;
    s_new_game = 1'b0; s_undo = 1'b0;

    vec[0] = mk(3, 4, 0, 1, 0, 1, 2, 1, 1, 0, 0);
    vec[1] = mk(3, 4, 0, 0, 2, 0, 2, 1, 1, 0, 0);
    vec[2] = mk(12, 0, 0, 0, 1, 0, 2, 1, 0, 0, 0);
    vec[3] = mk(0, 12, 0, 0, 1, 0, 2, 1, 0, 0, 0);
    vec[4] = mk(9, 9, 0, 1, 0, 2, 1, 2, 2, 0, 0);
    vec[5] = mk(10, 9, 0, 0, 1, 0, 1, 2, 0, 0, 0);
    vec[6] = mk(0, 0, 0, 1, 0, 1, 2, 3, 1, 0, 0);
    vec[7] = mk(9, 9, 0, 0, 2, 0, 2, 3, 2, 0, 0);
    vec[8] = mk(4, 5, 0, 1, 0, 2, 1, 4, 2, 0, 0);
    vec[9] = mk(5, 5, 1, 1, 0, 1, 1, 5, 1, 1, 1);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // reset state
    check("rst_ready", int'(move_ready), 1);
    check("rst_turn", int'(turn), 1);
    check("rst_count", int'(move_count), 0);
    check("rst_over", int'(game_over), 0);
    check("rst_winner", int'(winner), 0);
    check("rst_check_req", int'(check_req), 0);
    check("rst_accept", int'(move_accept), 0);
    check("rst_reject", int'(move_reject), 0);
    check("rst_code", int'(reject_code), 0);
    check("rst_recent_x", int'(recent_x), 0);
    check("rst_recent_y", int'(recent_y), 0);
    check("rst_piece", int'(piece_type), 0);
    check_board_empty("rst_board_empty");

    // 2x2 board: boundary reject then a four-move draw
    s_valid = 1'b1; s_x = 4'd2; s_y = 4'd0;
    @(posedge clk); #1;
    s_valid = 1'b0;
    check("d2_reject", int'(s_reject), 1);
    check("d2_reject_code", int'(s_code), 1);
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      s_valid = 1'b1; s_x = 4'(i % 2); s_y = 4'(i / 2);
      @(posedge clk); #1;
      s_valid = 1'b0;
      check("d2_accept", int'(s_accept), 1);
      check("d2_check_req", int'(s_check_req), 1);
      @(posedge clk); #1;
      check("d2_over", int'(s_over), (i == 3) ? 1 : 0);
      check("d2_winner", int'(s_winner), (i == 3) ? 3 : 0);
    end
    check("d2_count", int'(s_count), 4);
    check("d2_turn", int'(s_turn), 2);
    check("d2_ready", int'(s_ready), 0);
    check("d2_recent_x", int'(s_recent_x), 1);
    check("d2_recent_y", int'(s_recent_y), 1);
    check("d2_piece", int'(s_piece), 2);
    s_rd_x = 4'd0; s_rd_y = 4'd0; #1;
    check("d2_rd00", int'(s_rd_piece), 1);

    // table-driven moves on the 10x10 board, ending with a triangle win at (5,5)
    for (int i = 0; i < 10; i++) begin
      do_move(int'(vec[i].x), int'(vec[i].y), int'(vec[i].win), 0,
              mke(int'(vec[i].acc), int'(vec[i].code), int'(vec[i].x), int'(vec[i].y),
                  int'(vec[i].piece)));
      rd_x = vec[i].x; rd_y = vec[i].y; #1;
      check($sformatf("v%0d_turn", i), int'(turn), int'(vec[i].turn_after));
      check($sformatf("v%0d_count", i), int'(move_count), vec[i].cnt_after);
      check($sformatf("v%0d_rd", i), int'(rd_piece), int'(vec[i].rd_after));
      check($sformatf("v%0d_over", i), int'(game_over), int'(vec[i].over));
      check($sformatf("v%0d_winner", i), int'(winner), int'(vec[i].winner));
    end
    check("done_ready", int'(move_ready), 0);

    // moves presented in DONE are ignored
    pulses = 0;
    move_valid = 1'b1; move_x = 4'd6; move_y = 4'd6;
    repeat (4) begin
      @(negedge clk);
      if (move_accept || move_reject) pulses++;
    end
    move_valid = 1'b0;
    @(posedge clk); #1;
    check("done_pulses", pulses, 0);
    check("done_count", int'(move_count), 5);
    rd_x = 4'd6; rd_y = 4'd6; #1;
    check("done_rd66", int'(rd_piece), 0);

    // new_game from DONE: ten-cycle sweep, row 0 first
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    count_clear(1, cyc);
    check("sweep_cycles", cyc, 10);
    check_fresh("ng");
    check_board_empty("ng_board_empty");

    // restart the sweep mid-way
    do_move(0, 0, 0, 0, mke(1, 0, 0, 0, 1));
    do_move(9, 9, 0, 0, mke(1, 0, 9, 9, 2));
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    repeat (4) begin
      @(posedge clk); #1;
    end
    check("mid_sweep_ready", int'(move_ready), 0);
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    count_clear(0, cyc);
    check("restart_cycles", cyc, 10);
    check_fresh("rs");
    check_board_empty("rs_board_empty");

`ifdef BOARD_MOVE_UNDO_EN
    do_move(1, 1, 0, 0, mke(1, 0, 1, 1, 1));
    check("undo_pre_count", int'(move_count), 1);
    undo_req = 1'b1;
    @(posedge clk); #1;
    undo_req = 1'b0;
    rd_x = 4'd1; rd_y = 4'd1; #1;
    check("undo_rd11", int'(rd_piece), 0);
    check("undo_count", int'(move_count), 0);
    check("undo_turn", int'(turn), 1);
    undo_req = 1'b1;
    @(posedge clk); #1;
    undo_req = 1'b0;
    check("undo2_count", int'(move_count), 0);
    check("undo2_turn", int'(turn), 1);
    do_move(2, 2, 0, 0, mke(1, 0, 2, 2, 1));
    undo_req = 1'b1; move_valid = 1'b1; move_x = 4'd3; move_y = 4'd3;
    @(posedge clk); #1;
    undo_req = 1'b0; move_valid = 1'b0;
    @(posedge clk); #1;
    check("undo_vs_move_count", int'(move_count), 0);
    check("undo_vs_move_turn", int'(turn), 1);
    rd_x = 4'd3; rd_y = 4'd3; #1;
    check("undo_vs_move_rd33", int'(rd_piece), 0);
    rd_x = 4'd2; rd_y = 4'd2; #1;
    check("undo_vs_move_rd22", int'(rd_piece), 0);
    next_piece = 2'b01;
`else
    do_move(2, 2, 0, 1, mke(1, 0, 2, 2, 1));
    check("noundo_move_count", int'(move_count), 1);
    undo_req = 1'b1;
    @(posedge clk); #1;
    undo_req = 1'b0;
    @(posedge clk); #1;
    rd_x = 4'd2; rd_y = 4'd2; #1;
    check("noundo_rd22", int'(rd_piece), 1);
    check("noundo_count", int'(move_count), 1);
    check("noundo_turn", int'(turn), 2);
    next_piece = 2'b10;
`endif

    // rst in the middle of a sweep wipes the board at once
    do_move(7, 7, 0, 0, mke(1, 0, 7, 7, int'(next_piece)));
    new_game = 1'b1;
    @(posedge clk); #1;
    new_game = 1'b0;
    repeat (3) begin
      @(posedge clk); #1;
    end
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check_fresh("rst2");
    rd_x = 4'd7; rd_y = 4'd7; #1;
    check("rst2_rd77", int'(rd_piece), 0);
    check("rst2_check_req", int'(check_req), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
